// File: rtl/mem_ctrl_pkg.sv
// Shared types for the wait-state memory access controller: FSM states,
// the request snapshot layout and the masked request comparison.
package mem_ctrl_pkg;

   localparam int unsigned WAIT_CYCLES_DEF = 3;
   localparam int unsigned REQ_ADDR_W      = 64;
   localparam int unsigned REQ_DATA_W      = 128;
   localparam int unsigned REQ_BE_W        = REQ_DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RDY  = 2'd2
   } state_e;

   // Fields are sized for the widest supported channel; narrower channels zero-extend.
   typedef struct packed {
      logic [REQ_ADDR_W-1:0] if_addr;
      logic                  d_req;
      logic                  d_we;
      logic [REQ_ADDR_W-1:0] d_addr;
      logic [REQ_DATA_W-1:0] d_wdata;
      logic [REQ_BE_W-1:0]   d_be;
   } mem_req_t;

   // Data-side fields only matter when either snapshot actually requests data.
   function automatic logic req_differs(input mem_req_t live, input mem_req_t held);
      logic d_diff;
      d_diff = (live.d_we != held.d_we) || (live.d_addr != held.d_addr) ||
               (live.d_wdata != held.d_wdata) || (live.d_be != held.d_be);
      req_differs = (live.if_addr != held.if_addr) || (live.d_req != held.d_req) ||
                    ((live.d_req || held.d_req) && d_diff);
   endfunction

endpackage

// File: rtl/req_change_det.sv
// Holds the request seen at the start of a wait window and flags any later
// change to it while checking is enabled.
module req_change_det
   import mem_ctrl_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     capture,
   input  logic     check,
   input  mem_req_t live_req,
   output logic     mismatch
);

   mem_req_t held_d;
   mem_req_t held_q;

   // Next snapshot: take the live request when a window starts
   always_comb begin
      if (capture) begin
         held_d = live_req;
      end else begin
         held_d = held_q;
      end
   end

   // Snapshot register
   always_ff @(posedge clk) begin
      if (rst) begin
         held_q <= '0;
      end else begin
         held_q <= held_d;
      end
   end

   // Masked comparison against the snapshot
   always_comb begin
      if (check) begin
         mismatch = req_differs(live_req, held_q);
      end else begin
         mismatch = 1'b0;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Wait-state access controller: stalls the core until a fetch/data request has
// been stable for WAIT_CYCLES cycles, then releases a single ready cycle.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter  int unsigned ADDR_W      = 32,
   parameter  int unsigned DATA_W      = 32,
   parameter  int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
   localparam int unsigned BE_W        = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] instruction,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [BE_W-1:0]   d_be,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [BE_W-1:0]   dmem_be,
   output logic              dmem_we,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [DATA_W-1:0] load_data,
   output logic              stall,
   output logic              restart
);

   localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   state_e           state_d;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;
   mem_req_t         live_req;
   logic             mismatch;

   assign imem_addr  = if_addr;
   assign dmem_addr  = d_addr;
   assign dmem_wdata = d_wdata;
   assign dmem_be    = d_be;

   // Pack the live request into the shared snapshot layout
   always_comb begin
      live_req         = '0;
      live_req.if_addr = REQ_ADDR_W'(if_addr);
      live_req.d_req   = d_req;
      live_req.d_we    = d_we;
      live_req.d_addr  = REQ_ADDR_W'(d_addr);
      live_req.d_wdata = REQ_DATA_W'(d_wdata);
      live_req.d_be    = REQ_BE_W'(d_be);
   end

   req_change_det u_req_change_det (
      .clk      (clk),
      .rst      (rst),
      .capture  (cnt_q == {CNT_W{1'b0}}),
      .check    ((state_q == S_WAIT) && (cnt_q != {CNT_W{1'b0}})),
      .live_req (live_req),
      .mismatch (mismatch)
   );

   // FSM and wait counter next-state; a late change beats the terminal count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_WAIT;
            cnt_d   = {CNT_W{1'b0}};
         end
         S_WAIT: begin
            if (mismatch) begin
               state_d = S_WAIT;
               cnt_d   = {CNT_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_RDY;
               cnt_d   = cnt_q + CNT_W'(1);
            end else begin
               state_d = S_WAIT;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         S_RDY: begin
            state_d = S_WAIT;
            cnt_d   = {CNT_W{1'b0}};
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Core-facing outputs are only live during the single ready cycle
   always_comb begin
      stall       = 1'b1;
      instruction = {DATA_W{1'b0}};
      load_data   = {DATA_W{1'b0}};
      dmem_we     = 1'b0;
      restart     = mismatch;
      if (state_q == S_RDY) begin
         stall       = 1'b0;
         instruction = imem_rdata;
         dmem_we     = d_req & d_we;
         if (d_req && !d_we) begin
            load_data = dmem_rdata;
         end else begin
            load_data = {DATA_W{1'b0}};
         end
      end else begin
         stall = 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a window-based reference model checked
// every cycle, plus literal expectations at key cycles of each scenario.
module tb_mem_access_ctrl;

   localparam int WC = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_addr, imem_rdata, d_addr, d_wdata, dmem_rdata;
   logic        d_req, d_we;
   logic [3:0]  d_be;

   logic [31:0] imem_addr, instruction, dmem_addr, dmem_wdata, load_data;
   logic [3:0]  dmem_be;
   logic        dmem_we, stall, restart;

   logic [31:0] w1_imem_addr, w1_instruction, w1_dmem_addr, w1_dmem_wdata, w1_load_data;
   logic [3:0]  w1_dmem_be;
   logic        w1_dmem_we, w1_stall, w1_restart;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst), .if_addr(if_addr), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .instruction(instruction), .d_req(d_req),
      .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .load_data(load_data),
      .stall(stall), .restart(restart)
   );

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .rst(rst), .if_addr(if_addr), .imem_addr(w1_imem_addr),
      .imem_rdata(imem_rdata), .instruction(w1_instruction), .d_req(d_req),
      .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .dmem_addr(w1_dmem_addr), .dmem_wdata(w1_dmem_wdata), .dmem_be(w1_dmem_be),
      .dmem_we(w1_dmem_we), .dmem_rdata(dmem_rdata), .load_data(w1_load_data),
      .stall(w1_stall), .restart(w1_restart)
   );

   typedef struct packed {
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_be;
   } req_s;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit same_req(input req_s a, input req_s b);
      if (a.if_addr != b.if_addr || a.d_req != b.d_req) return 1'b0;
      if (!a.d_req && !b.d_req) return 1'b1;
      return a.d_we == b.d_we && a.d_addr == b.d_addr &&
             a.d_wdata == b.d_wdata && a.d_be == b.d_be;
   endfunction

   // Reference model: a window collects one identical request per wait cycle;
   // a full window yields the ready cycle, a differing request empties it.
   req_s        win[$];
   req_s        live;
   bit          m_idle = 1'b1;
   bit          m_rdy, m_rst_pulse;
   bit          w1_idle = 1'b1;
   bit          w1_ph = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         live        = '{if_addr, d_req, d_we, d_addr, d_wdata, d_be};
         m_rdy       = !m_idle && (win.size() == WC);
         m_rst_pulse = !m_idle && !m_rdy && (win.size() > 0) && !same_req(live, win[0]);
         chk("stall", 64'(stall), 64'(!m_rdy));
         chk("restart", 64'(restart), 64'(m_rst_pulse));
         chk("instruction", 64'(instruction), m_rdy ? 64'(imem_rdata) : 64'h0);
         chk("load_data", 64'(load_data), (m_rdy && d_req && !d_we) ? 64'(dmem_rdata) : 64'h0);
         chk("dmem_we", 64'(dmem_we), 64'(m_rdy && d_req && d_we));
         chk("imem_addr", 64'(imem_addr), 64'(if_addr));
         chk("dmem_path", {dmem_addr, dmem_wdata}, {d_addr, d_wdata});
         chk("dmem_be", 64'(dmem_be), 64'(d_be));
         if (rst) begin
            m_idle = 1'b1;
            win.delete();
         end else if (m_idle || m_rdy || m_rst_pulse) begin
            m_idle = 1'b0;
            win.delete();
         end else begin
            win.push_back(live);
         end

         chk("w1_stall", 64'(w1_stall), 64'(w1_idle || !w1_ph));
         chk("w1_restart", 64'(w1_restart), 64'h0);
         chk("w1_instruction", 64'(w1_instruction), (!w1_idle && w1_ph) ? 64'(imem_rdata) : 64'h0);
         chk("w1_dmem_we", 64'(w1_dmem_we), 64'(!w1_idle && w1_ph && d_req && d_we));
         if (rst) begin
            w1_idle = 1'b1;
            w1_ph   = 1'b0;
         end else if (w1_idle) begin
            w1_idle = 1'b0;
            w1_ph   = 1'b0;
         end else begin
            w1_ph = !w1_ph;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; if_addr = 32'h100; imem_rdata = 32'hDEADBEEF; dmem_rdata = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      cyc(1);
      chk("rst_stall", 64'(stall), 64'h1);
      chk("rst_restart", 64'(restart), 64'h0);
      chk("rst_instr", 64'(instruction), 64'h0);
      chk("rst_we_load", {31'h0, dmem_we, load_data}, 64'h0);

      // 1: basic fetch, IDLE plus three wait cycles then ready, period 4
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t1_stall_hold", 64'(stall), 64'h1);
         cyc(1);
      end
      chk("t1_ready", 64'(stall), 64'h0);
      chk("t1_instr", 64'(instruction), 64'hDEADBEEF);
      chk("t1_load", 64'(load_data), 64'h0);
      cyc(4);
      chk("t1_period", 64'(stall), 64'h0);

      // 2: fetch address change at cnt=1
      cyc(2);
      if_addr = 32'h200; imem_rdata = 32'h0BADF00D; #1;
      chk("t2_restart", 64'(restart), 64'h1);
      cyc(1);
      chk("t2_restart_once", 64'(restart), 64'h0);
      cyc(3);
      chk("t2_ready", 64'(stall), 64'h0);
      chk("t2_instr", 64'(instruction), 64'h0BADF00D);

      // 3: store commits only in the ready cycle
      cyc(1);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'hF; #1;
      for (int i = 0; i < 3; i++) begin
         chk("t3_we_early", 64'(dmem_we), 64'h0);
         cyc(1);
      end
      chk("t3_we", 64'(dmem_we), 64'h1);
      chk("t3_addr", 64'(dmem_addr), 64'h40);
      chk("t3_wdata", 64'(dmem_wdata), 64'h12345678);
      chk("t3_load", 64'(load_data), 64'h0);

      // 4: load result only in ready; masked data fields cause no restart
      cyc(1);
      d_we = 1'b0; dmem_rdata = 32'hCAFEF00D; #1;
      for (int i = 0; i < 3; i++) begin
         chk("t4_load_early", 64'(load_data), 64'h0);
         cyc(1);
      end
      chk("t4_load", 64'(load_data), 64'hCAFEF00D);
      chk("t4_we", 64'(dmem_we), 64'h0);
      cyc(1);
      d_req = 1'b0;
      cyc(1);
      d_wdata = 32'hFFFF0000; d_we = 1'b1; d_addr = 32'h44; #1;
      chk("t4_mask1", 64'(restart), 64'h0);
      cyc(1);
      d_wdata = 32'h0; d_be = 4'h3; #1;
      chk("t4_mask2", 64'(restart), 64'h0);
      cyc(1);
      chk("t4_ready", 64'(stall), 64'h0);
      chk("t4_no_store", 64'(dmem_we), 64'h0);

      // 5: reset at cnt=2 of a pending store
      cyc(1);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hA5A5A5A5; d_be = 4'hF;
      cyc(2);
      rst = 1'b1; #1;
      chk("t5_we_abort", 64'(dmem_we), 64'h0);
      cyc(1);
      chk("t5_idle_stall", 64'(stall), 64'h1);
      chk("t5_idle_outs", {instruction, load_data}, 64'h0);
      chk("t5_idle_we_rs", {62'h0, dmem_we, restart}, 64'h0);
      cyc(1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t5_we_quiet", 64'(dmem_we), 64'h0);
         cyc(1);
      end
      chk("t5_new_store", 64'(dmem_we), 64'h1);

      // 6: change on the terminal wait cycle suppresses ready
      cyc(3);
      d_addr = 32'h84; #1;
      chk("t6_restart", 64'(restart), 64'h1);
      chk("t6_no_ready", 64'(stall), 64'h1);
      cyc(4);
      chk("t6_ready", 64'(stall), 64'h0);
      chk("t6_we", 64'(dmem_we), 64'h1);
      chk("t6_addr", 64'(dmem_addr), 64'h84);

      // Mixed traffic, checked by the model alone
      for (int i = 0; i < 120; i++) begin
         cyc(1);
         rst = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 9))
            0: if_addr = 32'h100 + 32'($urandom_range(0, 3)) * 32'h4;
            1: d_req = ~d_req;
            2: d_we = ~d_we;
            3: d_addr = 32'($urandom_range(0, 255));
            4: d_wdata = $urandom;
            5: imem_rdata = $urandom;
            6: dmem_rdata = $urandom;
            7: d_be = 4'($urandom_range(0, 15));
            default: ;
         endcase
      end
      rst = 1'b0;
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
